// File: rtl/open_loop_flow_sched_pkg.sv
// Shared types for the multi-flow open-loop scheduler: app context, per-flow
// context, request record and flow lifecycle states.
package open_loop_flow_sched_pkg;

  localparam int MAX_INFLIGHT_DEF = 4;
  localparam int INFL_W_DEF       = 4;
  localparam int FLOWID_MAX_W     = 8;

  typedef enum logic [7:0] {SEND = 8'd0, RECV = 8'd1} client_dir_e;
  typedef enum logic [7:0] {FALSE = 8'd0, TRUE = 8'd1} bool_e;

  typedef struct packed {
    logic [31:0] total_reqs;
    logic [31:0] bufsize;
    logic [31:0] curr_reqs;
    bool_e       should_copy;
  } app_cntxt_struct;

  localparam int APP_CNTXT_W = $bits(app_cntxt_struct);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} flow_state_e;

  typedef struct packed {
    app_cntxt_struct       app;
    client_dir_e           dir;
    logic [31:0]           issued;
    logic [INFL_W_DEF-1:0] inflight;
  } flow_cntxt_struct;

  typedef struct packed {
    logic [FLOWID_MAX_W-1:0] flowid;
    client_dir_e             dir;
    logic [31:0]             len;
    logic                    copy;
  } sched_req_struct;

  typedef struct packed {
    logic [FLOWID_MAX_W-1:0] flowid;
    logic [31:0]             reqs;
  } done_struct;

endpackage

// File: rtl/open_loop_rr_arb.sv
// Round-robin picker over eligible flows; pointer moves past the winner only
// when the caller consumes the grant.
module open_loop_rr_arb #(
  parameter int NUM_FLOWS = 4,
  parameter int FLOWID_W  = $clog2(NUM_FLOWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_FLOWS-1:0] elig_i,
  input  logic                 adv_i,
  output logic                 grant_val_o,
  output logic [FLOWID_W-1:0]  grant_idx_o
);

  logic [FLOWID_W-1:0] ptr_q, ptr_d;
  logic [FLOWID_W-1:0] idx;

  // Scan from the farthest offset down so the closest eligible flow wins.
  always_comb begin
    grant_val_o = 1'b0;
    grant_idx_o = ptr_q;
    idx         = ptr_q;
    for (int i = NUM_FLOWS - 1; i >= 0; i--) begin
      idx = ptr_q + FLOWID_W'(i);
      if (elig_i[idx]) begin
        grant_val_o = 1'b1;
        grant_idx_o = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && grant_val_o) ptr_d = grant_idx_o + FLOWID_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/open_loop_flow_sched.sv
// Multi-flow open-loop request scheduler. Define OPEN_LOOP_FLOW_STATS_EN to add
// per-flow active-cycle counters reported on done_cycles.
module open_loop_flow_sched
  import open_loop_flow_sched_pkg::*;
#(
  parameter int NUM_FLOWS    = 4,
  parameter int FLOWID_W     = $clog2(NUM_FLOWS),
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int INFL_W       = INFL_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   setup_val,
  input  logic [FLOWID_W-1:0]    setup_flowid,
  input  logic [7:0]             setup_dir,
  input  logic [APP_CNTXT_W-1:0] setup_cntxt,
  output logic                   setup_rdy,
  output logic                   req_val,
  output logic [FLOWID_W-1:0]    req_flowid,
  output logic [7:0]             req_dir,
  output logic [31:0]            req_len,
  output logic                   req_copy,
  input  logic                   req_rdy,
  input  logic                   cmpl_val,
  input  logic [FLOWID_W-1:0]    cmpl_flowid,
  output logic                   cmpl_rdy,
  output logic                   done_val,
  output logic [FLOWID_W-1:0]    done_flowid,
  output logic [31:0]            done_reqs,
  input  logic                   done_rdy,
`ifdef OPEN_LOOP_FLOW_STATS_EN
  output logic                   err_sticky,
  output logic [31:0]            done_cycles
`else
  output logic                   err_sticky
`endif
);

  flow_state_e      st_q [NUM_FLOWS];
  flow_state_e      st_d [NUM_FLOWS];
  flow_cntxt_struct fl_q [NUM_FLOWS];
  flow_cntxt_struct fl_d [NUM_FLOWS];
  sched_req_struct  req_q, req_d;
  logic             req_val_q, req_val_d;
  logic             err_q, err_d;
  logic             hold_q, hold_d;
  logic [FLOWID_W-1:0]  hold_idx_q, hold_idx_d;
  logic [NUM_FLOWS-1:0] elig, done_vec, pend;
  logic                 grant_val, ld, req_hs, done_hs;
  logic [FLOWID_W-1:0]  grant_idx, done_pe, done_idx;
  app_cntxt_struct      setup_c;

  assign setup_c   = app_cntxt_struct'(setup_cntxt);
  assign setup_rdy = (st_q[setup_flowid] == IDLE);
  assign cmpl_rdy  = 1'b1;
  assign req_hs    = req_val_q & req_rdy;
  assign ld        = !req_val_q || req_rdy;

  // The request sitting in the output register is counted against its flow so
  // back-to-back loads never overshoot total_reqs or MAX_INFLIGHT.
  always_comb begin
    elig     = '0;
    done_vec = '0;
    pend     = '0;
    done_pe  = '0;
    for (int f = NUM_FLOWS - 1; f >= 0; f--) begin
      pend[f] = req_val_q && (req_q.flowid == FLOWID_MAX_W'(f));
      elig[f] = (st_q[f] == ACTIVE) &&
                ((fl_q[f].issued + 32'(pend[f])) < fl_q[f].app.total_reqs) &&
                (((INFL_W+1)'(fl_q[f].inflight) + (INFL_W+1)'(pend[f])) <
                 (INFL_W+1)'(MAX_INFLIGHT));
      done_vec[f] = (st_q[f] == DONE);
      if (done_vec[f]) done_pe = FLOWID_W'(f);
    end
  end

  open_loop_rr_arb #(.NUM_FLOWS(NUM_FLOWS), .FLOWID_W(FLOWID_W)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .elig_i      (elig),
    .adv_i       (ld),
    .grant_val_o (grant_val),
    .grant_idx_o (grant_idx)
  );

  // Done reporting locks onto one flow until it is accepted.
  assign done_val    = |done_vec;
  assign done_idx    = hold_q ? hold_idx_q : done_pe;
  assign done_hs     = done_val & done_rdy;
  assign done_flowid = done_idx;
  assign done_reqs   = fl_q[done_idx].app.curr_reqs;
  assign hold_d      = done_val & !done_rdy;
  assign hold_idx_d  = done_idx;

  always_comb begin
    st_d  = st_q;
    fl_d  = fl_q;
    err_d = err_q;
    for (int f = 0; f < NUM_FLOWS; f++) begin
      logic iss, cmp, cok;
      iss = req_hs && (req_q.flowid == FLOWID_MAX_W'(f));
      cmp = cmpl_val && (cmpl_flowid == FLOWID_W'(f));
      cok = cmp && (st_q[f] == ACTIVE || st_q[f] == DRAIN) && (fl_q[f].inflight != '0);
      if (cmp && !cok) err_d = 1'b1;
      if (iss) fl_d[f].issued = fl_q[f].issued + 32'd1;
      if (cok) fl_d[f].app.curr_reqs = fl_q[f].app.curr_reqs + 32'd1;
      fl_d[f].inflight = fl_q[f].inflight + INFL_W_DEF'(iss) - INFL_W_DEF'(cok);
      case (st_q[f])
        IDLE: if (setup_val && setup_flowid == FLOWID_W'(f)) begin
          fl_d[f].app           = setup_c;
          fl_d[f].app.curr_reqs = '0;
          fl_d[f].dir           = client_dir_e'(setup_dir);
          fl_d[f].issued        = '0;
          fl_d[f].inflight      = '0;
          st_d[f] = (setup_c.total_reqs == '0) ? DONE : ACTIVE;
        end
        ACTIVE: if (fl_d[f].issued == fl_q[f].app.total_reqs) st_d[f] = DRAIN;
        DRAIN:  if (fl_d[f].app.curr_reqs == fl_q[f].app.total_reqs) st_d[f] = DONE;
        DONE:   if (done_hs && done_idx == FLOWID_W'(f)) st_d[f] = IDLE;
      endcase
    end
  end

  always_comb begin
    req_val_d = ld ? grant_val : req_val_q;
    req_d     = req_q;
    if (ld && grant_val) begin
      req_d.flowid = FLOWID_MAX_W'(grant_idx);
      req_d.dir    = fl_q[grant_idx].dir;
      req_d.len    = fl_q[grant_idx].app.bufsize;
      req_d.copy   = (fl_q[grant_idx].app.should_copy == TRUE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < NUM_FLOWS; f++) begin
        st_q[f] <= IDLE;
        fl_q[f] <= '0;
      end
      req_q      <= '0;
      req_val_q  <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      st_q       <= st_d;
      fl_q       <= fl_d;
      req_q      <= req_d;
      req_val_q  <= req_val_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
    end
  end

  assign req_val    = req_val_q;
  assign req_flowid = req_q.flowid[FLOWID_W-1:0];
  assign req_dir    = req_q.dir;
  assign req_len    = req_q.len;
  assign req_copy   = req_q.copy;
  assign err_sticky = err_q;

`ifdef OPEN_LOOP_FLOW_STATS_EN
  logic [31:0] cyc_q [NUM_FLOWS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < NUM_FLOWS; f++) cyc_q[f] <= '0;
    end else begin
      for (int f = 0; f < NUM_FLOWS; f++) begin
        if (st_q[f] == IDLE && setup_val && setup_flowid == FLOWID_W'(f))
          cyc_q[f] <= '0;
        else if ((st_q[f] == ACTIVE || st_q[f] == DRAIN) && cyc_q[f] != '1)
          cyc_q[f] <= cyc_q[f] + 32'd1;
      end
    end
  end

  assign done_cycles = cyc_q[done_idx];
`endif

endmodule

// File: tb/tb_open_loop_flow_sched.sv
// Directed bench for open_loop_flow_sched: single flow, round-robin over four
// flows, inflight limit, zero-length flow, error/setup guards, mid-run reset.
module tb_open_loop_flow_sched;
  import open_loop_flow_sched_pkg::*;

  localparam int NF = 4;
  localparam int FW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic setup_val = 1'b0;
  logic [FW-1:0] setup_flowid = '0;
  logic [7:0] setup_dir = '0;
  logic [APP_CNTXT_W-1:0] setup_cntxt = '0;
  logic setup_rdy;
  logic req_val;
  logic [FW-1:0] req_flowid;
  logic [7:0] req_dir;
  logic [31:0] req_len;
  logic req_copy;
  logic req_rdy = 1'b0;
  logic cmpl_val = 1'b0;
  logic [FW-1:0] cmpl_flowid = '0;
  logic cmpl_rdy;
  logic done_val;
  logic [FW-1:0] done_flowid;
  logic [31:0] done_reqs;
  logic done_rdy = 1'b0;
  logic err_sticky;
`ifdef OPEN_LOOP_FLOW_STATS_EN
  logic [31:0] done_cycles;
`endif

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  open_loop_flow_sched #(.NUM_FLOWS(NF), .MAX_INFLIGHT(4)) dut (
    .clk(clk), .rst(rst),
    .setup_val(setup_val), .setup_flowid(setup_flowid), .setup_dir(setup_dir),
    .setup_cntxt(setup_cntxt), .setup_rdy(setup_rdy),
    .req_val(req_val), .req_flowid(req_flowid), .req_dir(req_dir),
    .req_len(req_len), .req_copy(req_copy), .req_rdy(req_rdy),
    .cmpl_val(cmpl_val), .cmpl_flowid(cmpl_flowid), .cmpl_rdy(cmpl_rdy),
    .done_val(done_val), .done_flowid(done_flowid), .done_reqs(done_reqs),
    .done_rdy(done_rdy),
`ifdef OPEN_LOOP_FLOW_STATS_EN
    .done_cycles(done_cycles),
`endif
    .err_sticky(err_sticky)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; setup_val = 1'b0; req_rdy = 1'b0; cmpl_val = 1'b0; done_rdy = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic setup(input int f, input logic [7:0] dir, input int total, input int bsz, input bit copy);
    app_cntxt_struct c;
    c.total_reqs  = total;
    c.bufsize     = bsz;
    c.curr_reqs   = 32'hdead;
    c.should_copy = copy ? TRUE : FALSE;
    setup_val = 1'b1; setup_flowid = FW'(f); setup_dir = dir; setup_cntxt = c;
    step();
    setup_val = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (req_val !== 1'b0) begin errs++; $display("FAIL reset_req_val: got %0b want 0", req_val); end
    checks++; if (done_val !== 1'b0) begin errs++; $display("FAIL reset_done_val: got %0b want 0", done_val); end
    checks++; if (err_sticky !== 1'b0) begin errs++; $display("FAIL reset_err: got %0b want 0", err_sticky); end
    checks++; if (cmpl_rdy !== 1'b1) begin errs++; $display("FAIL cmpl_rdy: got %0b want 1", cmpl_rdy); end
    for (int f = 0; f < NF; f++) begin
      setup_flowid = FW'(f); #1;
      checks++; if (setup_rdy !== 1'b1) begin errs++; $display("FAIL reset_setup_rdy[%0d]: got %0b want 1", f, setup_rdy); end
    end
  endtask

  task automatic test_single_flow();
    int nreq = 0;
    bit prev = 0, got = 0;
    logic [FW-1:0] pf = '0;
    do_reset();
    req_rdy = 1'b1;
    setup(0, SEND, 3, 64, 1'b1);
    for (int c = 0; c < 40 && !got; c++) begin
      cmpl_val = prev; cmpl_flowid = pf; prev = 0;
      #1;
      if (req_val) begin
        nreq++; prev = 1; pf = req_flowid;
        checks++; if (req_flowid !== 2'd0) begin errs++; $display("FAIL single_flowid: got %0d want 0", req_flowid); end
        checks++; if (req_len !== 32'd64) begin errs++; $display("FAIL single_len: got %0d want 64", req_len); end
        checks++; if (req_dir !== 8'(SEND) || req_copy !== 1'b1) begin errs++; $display("FAIL single_dir_copy: got %0d/%0b want 0/1", req_dir, req_copy); end
      end
      if (done_val) begin
        got = 1; done_rdy = 1'b1;
        checks++; if (done_flowid !== 2'd0) begin errs++; $display("FAIL single_done_flowid: got %0d want 0", done_flowid); end
        checks++; if (done_reqs !== 32'd3) begin errs++; $display("FAIL single_done_reqs: got %0d want 3", done_reqs); end
      end
      step();
    end
    done_rdy = 1'b0; cmpl_val = 1'b0;
    checks++; if (!got) begin errs++; $display("FAIL single_done_timeout: got 0 want 1"); end
    checks++; if (nreq != 3) begin errs++; $display("FAIL single_nreq: got %0d want 3", nreq); end
    setup_flowid = 2'd0; #1;
    checks++; if (setup_rdy !== 1'b1) begin errs++; $display("FAIL single_back_idle: got %0b want 1", setup_rdy); end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    bit prev = 0;
    logic [FW-1:0] pf = '0;
    logic [NF-1:0] mask = '0;
    do_reset();
    for (int f = 0; f < NF; f++) setup(f, RECV, 2, 16 * (f + 1), 1'b0);
    req_rdy = 1'b1; done_rdy = 1'b1;
    for (int c = 0; c < 80 && mask != 4'hf; c++) begin
      cmpl_val = prev; cmpl_flowid = pf; prev = 0;
      #1;
      if (req_val) begin
        order.push_back(int'(req_flowid)); prev = 1; pf = req_flowid;
        checks++; if (req_len !== 32'(16 * (int'(req_flowid) + 1))) begin errs++; $display("FAIL rr_len: flow %0d got %0d want %0d", req_flowid, req_len, 16 * (int'(req_flowid) + 1)); end
      end
      if (done_val) begin
        mask[done_flowid] = 1'b1;
        checks++; if (done_reqs !== 32'd2) begin errs++; $display("FAIL rr_done_reqs: flow %0d got %0d want 2", done_flowid, done_reqs); end
      end
      step();
    end
    done_rdy = 1'b0; cmpl_val = 1'b0; req_rdy = 1'b0;
    checks++; if (mask !== 4'hf) begin errs++; $display("FAIL rr_all_done: got %0h want f", mask); end
    checks++; if (order.size() != 8) begin errs++; $display("FAIL rr_count: got %0d want 8", order.size()); end
    for (int i = 0; i < 8 && i < order.size(); i++) begin
      checks++; if (order[i] != exp_order[i]) begin errs++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], exp_order[i]); end
    end
  endtask

  task automatic test_inflight_limit();
    int n = 0;
    do_reset();
    req_rdy = 1'b1;
    setup(1, RECV, 10, 8, 1'b0);
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_val) begin
        if (n == 0) begin
          checks++; if (req_dir !== 8'(RECV) || req_copy !== 1'b0 || req_flowid !== 2'd1) begin errs++; $display("FAIL infl_fields: got dir %0d copy %0b flow %0d want 1/0/1", req_dir, req_copy, req_flowid); end
        end
        n++;
      end
      step();
    end
    #1;
    checks++; if (n != 4) begin errs++; $display("FAIL infl_cap: got %0d want 4", n); end
    checks++; if (req_val !== 1'b0) begin errs++; $display("FAIL infl_stall: got %0b want 0", req_val); end
    cmpl_val = 1'b1; cmpl_flowid = 2'd1;
    step();
    cmpl_val = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      #1; if (req_val) n++;
      step();
    end
    checks++; if (n != 1) begin errs++; $display("FAIL infl_refill: got %0d want 1", n); end
    checks++; if (err_sticky !== 1'b0) begin errs++; $display("FAIL infl_err: got %0b want 0", err_sticky); end
    req_rdy = 1'b0;
  endtask

  task automatic test_zero_total();
    do_reset();
    req_rdy = 1'b1;
    setup(2, SEND, 0, 32, 1'b0);
    #1;
    checks++; if (done_val !== 1'b1) begin errs++; $display("FAIL zero_done_val: got %0b want 1", done_val); end
    checks++; if (done_flowid !== 2'd2) begin errs++; $display("FAIL zero_done_flowid: got %0d want 2", done_flowid); end
    checks++; if (done_reqs !== 32'd0) begin errs++; $display("FAIL zero_done_reqs: got %0d want 0", done_reqs); end
    checks++; if (req_val !== 1'b0) begin errs++; $display("FAIL zero_no_req: got %0b want 0", req_val); end
    done_rdy = 1'b1;
    step();
    done_rdy = 1'b0; setup_flowid = 2'd2; #1;
    checks++; if (done_val !== 1'b0) begin errs++; $display("FAIL zero_done_clear: got %0b want 0", done_val); end
    checks++; if (setup_rdy !== 1'b1) begin errs++; $display("FAIL zero_back_idle: got %0b want 1", setup_rdy); end
    checks++; if (req_val !== 1'b0) begin errs++; $display("FAIL zero_no_req2: got %0b want 0", req_val); end
    req_rdy = 1'b0;
  endtask

  task automatic test_err_and_setup_guard();
    do_reset();
    cmpl_val = 1'b1; cmpl_flowid = 2'd3;
    step();
    cmpl_val = 1'b0; setup_flowid = 2'd3; #1;
    checks++; if (err_sticky !== 1'b1) begin errs++; $display("FAIL err_idle_cmpl: got %0b want 1", err_sticky); end
    checks++; if (setup_rdy !== 1'b1) begin errs++; $display("FAIL err_no_state_change: got %0b want 1", setup_rdy); end
    checks++; if (done_val !== 1'b0 || req_val !== 1'b0) begin errs++; $display("FAIL err_side_effect: got done %0b req %0b want 0/0", done_val, req_val); end
    setup(0, SEND, 5, 4, 1'b0);
    setup_flowid = 2'd0; #1;
    checks++; if (setup_rdy !== 1'b0) begin errs++; $display("FAIL setup_rdy_active: got %0b want 0", setup_rdy); end
    step(); step(); #1;
    checks++; if (err_sticky !== 1'b1) begin errs++; $display("FAIL err_sticky_hold: got %0b want 1", err_sticky); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    req_rdy = 1'b1;
    setup(0, SEND, 1, 4, 1'b0);
    setup(1, SEND, 10, 4, 1'b0);
    step(); step();
    req_rdy = 1'b0;
    step();
    setup_flowid = 2'd0; #1;
    checks++; if (req_val !== 1'b1) begin errs++; $display("FAIL mid_pre_req_val: got %0b want 1", req_val); end
    checks++; if (setup_rdy !== 1'b0) begin errs++; $display("FAIL mid_pre_flow0_busy: got %0b want 0", setup_rdy); end
    rst = 1'b1;
    step(); #1;
    checks++; if (req_val !== 1'b0) begin errs++; $display("FAIL mid_req_val: got %0b want 0", req_val); end
    checks++; if (done_val !== 1'b0) begin errs++; $display("FAIL mid_done_val: got %0b want 0", done_val); end
    for (int f = 0; f < NF; f++) begin
      setup_flowid = FW'(f); #1;
      checks++; if (setup_rdy !== 1'b1) begin errs++; $display("FAIL mid_setup_rdy[%0d]: got %0b want 1", f, setup_rdy); end
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    test_reset();
    test_single_flow();
    test_round_robin();
    test_inflight_limit();
    test_zero_total();
    test_err_and_setup_guard();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
